// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the memory (slave).
// Single outstanding request: dmem_req is held with stable address/data/enables until dmem_ack.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on mem_stage_if, formats load data, registers writeback.
// Optional WAIT-state timeout with bus_err reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // Upstream handshake: an op is accepted on a rising edge with in_valid && in_ready.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rs2_forward,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_size,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbg_state
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

  state_t      state_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_reg_write_q;
  logic        misalign_q;
  logic        bus_err_q;

  // Context of the outstanding transaction, needed to retire it on ack.
  logic        pend_store_q;
  size_t       pend_size_q;
  logic        pend_uns_q;
  logic [1:0]  pend_off_q;
  logic [4:0]  pend_rd_q;
  logic        pend_rw_q;
  logic [31:0] pend_alu_q;

  size_t       in_size;
  logic        in_uns;
  logic        in_is_mem;
  logic        in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    in_size = SZ_W;
    case (mem_size)
      3'b000, 3'b100: in_size = SZ_B;
      3'b001, 3'b101: in_size = SZ_H;
      default:        in_size = SZ_W;
    endcase
    in_uns      = mem_size[2];
    in_is_mem   = mem_read | mem_write;
    in_misalign = ((in_size == SZ_H) && ALU_result[0]) ||
                  ((in_size == SZ_W) && (ALU_result[1:0] != 2'b00));
  end

  always_comb begin
    in_be    = 4'b1111;
    in_wdata = rs2_forward;
    case (in_size)
      SZ_B: begin
        in_be    = 4'b0001 << ALU_result[1:0];
        in_wdata = {4{rs2_forward[7:0]}};
      end
      SZ_H: begin
        in_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{rs2_forward[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = rs2_forward;
      end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input size_t sz, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (sz)
      SZ_B:    fmt_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    fmt_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: fmt_load = rdata;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
      pend_store_q   <= 1'b0;
      pend_size_q    <= SZ_W;
      pend_uns_q     <= 1'b0;
      pend_off_q     <= '0;
      pend_rd_q      <= '0;
      pend_rw_q      <= 1'b0;
      pend_alu_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!in_is_mem) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= ALU_result;
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= reg_write_in;
            end else if (in_misalign) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= ALU_result;
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= 1'b0;
              misalign_q     <= 1'b1;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= mem_write;
              dmem_addr_q  <= {ALU_result[31:2], 2'b00};
              dmem_wdata_q <= in_wdata;
              dmem_be_q    <= in_be;
              pend_store_q <= mem_write;
              pend_size_q  <= in_size;
              pend_uns_q   <= in_uns;
              pend_off_q   <= ALU_result[1:0];
              pend_rd_q    <= rd_in;
              pend_rw_q    <= reg_write_in;
              pend_alu_q   <= ALU_result;
              state_q      <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
              to_cnt_q     <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          // An ack on the same edge as the timeout takes priority.
          if (dmem.dmem_ack) begin
            dmem_req_q     <= 1'b0;
            state_q        <= S_IDLE;
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= pend_rd_q;
            wb_data_q      <= pend_store_q ? pend_alu_q
                                           : fmt_load(dmem.dmem_rdata, pend_off_q, pend_size_q, pend_uns_q);
            wb_reg_write_q <= pend_store_q ? 1'b0 : pend_rw_q;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt_q == CNT_LAST) begin
            dmem_req_q     <= 1'b0;
            state_q        <= S_IDLE;
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= pend_rd_q;
            wb_data_q      <= pend_alu_q;
            wb_reg_write_q <= 1'b0;
            bus_err_q      <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign dbg_state       = state_q;
  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign dmem.dmem_be    = dmem_be_q;
  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign misalign        = misalign_q;
  assign bus_err         = bus_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of EX_stage. Consumes ALU_result (effective address or ALU value) and rs2_forward (store data), plus load/store control.
- Drives a single-outstanding request/acknowledge data-memory bus.
- Formats load data (byte/half/word, sign/zero extension) and presents a registered result to writeback.
- Stalls upstream (in_ready low) while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  EX presents an operation
- in_ready  output  1  stage can accept; 1 in IDLE, 0 in WAIT
- ALU_result  input  32  address (load/store) or result (other)
- rs2_forward  input  32  store data
- mem_read  input  1  load
- mem_write  input  1  store
- mem_size  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_in  input  5  destination register
- reg_write_in  input  1  writeback enable from decode
- dmem_req  output  1  bus request, held until ack
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word-aligned address {ALU_result[31:2],2'b00}
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_rdata  input  32  read data, valid with ack
- dmem_ack  input  1  transaction complete
- wb_valid  output  1  one-cycle pulse per retired op
- wb_data  output  32  load data or passthrough ALU_result
- wb_rd  output  5  destination register
- wb_reg_write  output  1  writeback enable
- misalign  output  1  pulse with wb_valid on misaligned access
- bus_err  output  1  pulse with wb_valid on timeout (MEM_TIMEOUT_EN only)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All registered outputs clear to 0: dmem_*, wb_*, misalign, bus_err.
  - in_ready=1.
  - Reset during WAIT drops dmem_req immediately and discards the transaction.
- Accept: occurs on a rising edge with in_valid && in_ready.
- Non-memory op (mem_read=mem_write=0):
  - Next cycle: wb_valid=1, wb_data=ALU_result, wb_rd=rd_in, wb_reg_write=reg_write_in.
  - Latency 1; back-to-back accept allowed.
- Both mem_read and mem_write set: treated as a store.
- mem_size 011/110/111: treated as word.
- Alignment:
  - H/HU/SH requires addr[0]=0.
  - W requires addr[1:0]=00.
  - Misaligned op: no bus request. Next cycle wb_valid=1, wb_reg_write=0, misalign=1, wb_data=ALU_result.
- Aligned load/store at accept edge:
  - Register dmem_req=1, dmem_addr, dmem_we.
  - Register dmem_be: B = 1<<addr[1:0]; H = 0011 (addr[1]=0) or 1100; W = 1111.
  - Register dmem_wdata: B = {4{rs2[7:0]}}; H = {2{rs2[15:0]}}; W = rs2.
  - Enter WAIT. In WAIT, all dmem_* outputs are stable.
- In WAIT:
  - On an edge with dmem_ack=1: dmem_req=0, go to IDLE, wb_valid=1 next cycle. Minimum latency from accept to wb_valid is 2 cycles.
  - Load: bytes selected by addr[1:0]. B/H sign-extended, BU/HU zero-extended. wb_reg_write=reg_write_in.
  - Store: wb_reg_write=0, wb_data=ALU_result.
- dmem_ack while dmem_req=0: ignored.
- wb_valid deasserts the cycle after its pulse. wb_data/wb_rd hold their values until the next retire.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES with no ack: dmem_req=0, go to IDLE, next cycle wb_valid=1, wb_reg_write=0, bus_err=1.
  - An ack on the same edge as the timeout wins; bus_err stays 0.
- Undefined: no counter; WAIT persists indefinitely; bus_err tied 0.

Test Plan:
- ALU op: ALU_result=17, rd_in=5, reg_write_in=1 -> next cycle wb_valid=1, wb_data=17, wb_rd=5, wb_reg_write=1.
- SB, addr 0x102, rs2=0xAB -> dmem_addr=0x100, dmem_be=0100, dmem_wdata=0xABABABAB, dmem_we=1. in_ready=0 until ack; wb_reg_write=0.
- LB, addr 0x203, rdata=0x80FFFFFF, ack after 3 cycles -> wb_data=0xFFFFFF80. Same with LBU -> 0x00000080.
- LW, addr 0x102 -> no dmem_req; next cycle misalign=1, wb_reg_write=0.
- LH, addr 0x10, ack held low, rst_n pulsed low mid-WAIT -> dmem_req=0 immediately, in_ready=1, no wb_valid.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, LW, addr 0x40, no ack -> after 4 WAIT cycles dmem_req=0; next cycle bus_err=1, wb_valid=1.
